config_reg_master: RTL
======================

Name: config_reg_master

Overview:
- Host-side initiator for the 8 x 16-bit config_reg register file.
- Accepts write/read commands over a valid/ready port and drives the config_reg write/address/data_in pins. Captures config_reg data_out for reads and write read-back verification.
- Returns one response per command and keeps a saturating count of verify failures.
- Sits between the control sequencer and config_reg.

Parameters:
- DATA_W, 16, register data width.
- ADDR_W, 3, register address width (8 registers).
- MAX_RETRY, 2, number of re-writes after a verify mismatch before an error is reported.
- ERR_CNT_W, 8, width of the verify-failure counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  master can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target register.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data, or last read-back value for a write.
- rsp_error  out  1  write verify failed after all retries.
- err_count  out  ERR_CNT_W  saturating count of failed writes.
- write  out  1  config_reg write strobe.
- address  out  ADDR_W  config_reg address.
- data_in  out  DATA_W  config_reg write data.
- data_out  in  DATA_W  config_reg read data; combinational from address, valid the cycle after address is stable.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, write=0, address=0, data_in=0, cmd_ready=0 while reset is asserted, rsp_valid=0, rsp_rdata=0, rsp_error=0, err_count=0, retry count=0.
- States: IDLE, WRITE, SETTLE, CHECK, READ, CAPTURE, RESP.
- IDLE: cmd_ready=1. A command is accepted on the clk edge where cmd_valid && cmd_ready. The accepted address and data are registered onto address/data_in, and the state moves to WRITE (cmd_write=1) or READ.
- WRITE: write=1 for exactly one cycle; address and data_in held.
  - With verification compiled in: go to SETTLE.
  - Without it: go to RESP with rsp_rdata=cmd_wdata and rsp_error=0.
- SETTLE: write=0, address held; config_reg data_out settles.
- CHECK: capture data_out into rsp_rdata.
  - Match: go to RESP, rsp_error=0.
  - Mismatch and retry < MAX_RETRY: retry+1, back to WRITE.
  - Mismatch and retry == MAX_RETRY: go to RESP, rsp_error=1, err_count+1 saturating at all-ones.
- READ: write=0, address held. CAPTURE: rsp_rdata <= data_out, rsp_error=0, go to RESP.
- RESP: rsp_valid=1; rsp_rdata and rsp_error held stable until rsp_ready is high. On the handshake: rsp_valid=0, retry=0, go to IDLE.
- cmd_ready=0 in every state other than IDLE, so there is one outstanding command at most.
- Latency from the accept edge to rsp_valid:
  - Write, verification compiled in: 4 cycles, plus 3 per retry.
  - Write, verification compiled out: 2 cycles.
  - Read: 3 cycles.
- write is never asserted outside WRITE. address and data_in keep their last values in IDLE.
- An out-of-range address cannot occur: ADDR_W covers all 8 registers.
- Reset mid-operation: write drops immediately, any pending response is discarded, state returns to IDLE, err_count clears.

Optional Feature:
- Macro: CONFIG_REG_MASTER_VERIFY_EN.
- Defined: write read-back verification, the retry path and err_count are active as described above.
- Undefined: SETTLE and CHECK are removed, WRITE goes directly to RESP, rsp_error is tied to 0 and err_count is tied to 0.

Decomposition:
- Package config_reg_pkg holds:
  - the register enum: adc0_reg, adc1_reg, temp_sensor0_reg, temp_sensor1_reg, analog_test, digital_test, amp_gain, digital_config, encoded 0..7;
  - the ADDR_W and DATA_W constants;
  - the reset-value constant array: index 7=16'h0001, 4=16'hABCD, 0=16'hFFFF, all others 16'h0000;
  - the master state enum.
- No sub-module is required; the master is a single FSM with datapath registers.

Test Plan:
- After reset, read analog_test (addr 4) -> rsp_rdata=16'hABCD, rsp_error=0, rsp_valid 3 cycles after accept.
- Write amp_gain (addr 6) = 16'hABCD with verification compiled in -> exactly one write pulse with address=6 and data_in=16'hABCD; rsp_valid 4 cycles after accept; rsp_rdata=16'hABCD; rsp_error=0.
- config_reg model with data_out bit 0 stuck at 0, write digital_config (addr 7) = 16'h0001 -> 3 write pulses, rsp_error=1, rsp_rdata=16'h0000, err_count=1.
- Hold rsp_ready=0 for 5 cycles after a read of adc0_reg (addr 0) -> rsp_valid stays 1, rsp_rdata stays 16'hFFFF, cmd_ready stays 0. A new cmd_valid is not accepted until the cycle after the rsp handshake.
- Assert reset during SETTLE of a write -> write=0 and rsp_valid=0 immediately, err_count=0; after release, cmd_ready=1.
- Verification compiled out, write adc1_reg (addr 1) = 16'h5EAB -> rsp_valid 2 cycles after accept; a following read of addr 1 returns 16'h5EAB.

Source files
------------

// File: rtl/config_reg_pkg.sv
// Shared definitions for the config_reg register file and its host-side master:
// register map, widths, power-on register values and master FSM state codes.
package config_reg_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 16;

  typedef enum logic [ADDR_W-1:0] {
    adc0_reg         = 3'd0,
    adc1_reg         = 3'd1,
    temp_sensor0_reg = 3'd2,
    temp_sensor1_reg = 3'd3,
    analog_test      = 3'd4,
    digital_test     = 3'd5,
    amp_gain         = 3'd6,
    digital_config   = 3'd7
  } config_reg_e;

  // Value each register holds after config_reg comes out of reset, indexed by address.
  localparam logic [DATA_W-1:0] REG_RESET_VAL [0:7] = '{
    16'hFFFF, 16'h0000, 16'h0000, 16'h0000,
    16'hABCD, 16'h0000, 16'h0000, 16'h0001
  };

  // Master FSM state codes, kept as plain constants so legacy code can compare them directly.
  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] S_WRITE   = 3'd1;
  localparam logic [STATE_W-1:0] S_SETTLE  = 3'd2;
  localparam logic [STATE_W-1:0] S_CHECK   = 3'd3;
  localparam logic [STATE_W-1:0] S_READ    = 3'd4;
  localparam logic [STATE_W-1:0] S_CAPTURE = 3'd5;
  localparam logic [STATE_W-1:0] S_RESP    = 3'd6;

endpackage

// File: rtl/config_reg_master.sv
// Host-side initiator for the 8 x 16-bit config_reg register file.
// Takes one write/read command at a time over a valid/ready port, drives the
// config_reg write/address/data_in pins and returns one response per command.
// Build option: define CONFIG_REG_MASTER_VERIFY_EN to enable write read-back
// verification with retries and the saturating verify-failure counter; without
// it a write completes straight after the strobe and rsp_error/err_count read 0.
module config_reg_master #(
  parameter int DATA_W    = config_reg_pkg::DATA_W,
  parameter int ADDR_W    = config_reg_pkg::ADDR_W,
  parameter int MAX_RETRY = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic              write,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out
);

  import config_reg_pkg::*;

  logic [STATE_W-1:0] state;

  // Ready only while idle and out of reset, so at most one command is ever outstanding.
  assign cmd_ready = reset && (state == S_IDLE);

`ifdef CONFIG_REG_MASTER_VERIFY_EN
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic [RETRY_W-1:0] retry_cnt;

  // Command sequencing with read-back verification: strobe, let data_out settle, compare, retry or report.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      write     <= 1'b0;
      address   <= '0;
      data_in   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      err_count <= '0;
      retry_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            address <= cmd_addr;
            data_in <= cmd_wdata;
            if (cmd_write) begin
              state <= S_WRITE;
              write <= 1'b1;
            end else begin
              state <= S_READ;
            end
          end
        end
        S_WRITE: begin
          write <= 1'b0;
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          state <= S_CHECK;
        end
        S_CHECK: begin
          rsp_rdata <= data_out;
          if (data_out == data_in) begin
            rsp_error <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
            retry_cnt <= retry_cnt + 1'b1;
            write     <= 1'b1;
            state     <= S_WRITE;
          end else begin
            rsp_error <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
            if (err_count != '1) begin
              err_count <= err_count + 1'b1;
            end
          end
        end
        S_READ: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          rsp_rdata <= data_out;
          rsp_error <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            retry_cnt <= '0;
            state     <= S_IDLE;
          end
        end
        default: begin
          write     <= 1'b0;
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end
`else
  assign rsp_error = 1'b0;
  assign err_count = '0;

  // Command sequencing without verification: a write completes right after its strobe, echoing the written data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      write     <= 1'b0;
      address   <= '0;
      data_in   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            address <= cmd_addr;
            data_in <= cmd_wdata;
            if (cmd_write) begin
              state <= S_WRITE;
              write <= 1'b1;
            end else begin
              state <= S_READ;
            end
          end
        end
        S_WRITE: begin
          write     <= 1'b0;
          rsp_rdata <= data_in;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_READ: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          rsp_rdata <= data_out;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          write     <= 1'b0;
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end
`endif

endmodule
